// File: rtl/vortex_launch_ctrl.sv
// Kernel launch sequencer in front of the Vortex core.
// Accepts one launch descriptor, streams its DCR words to the core while the
// core is held in reset, releases reset, tracks busy through start and
// completion (with start timeout and host abort), then reports a completion
// record over a valid/ready channel.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   launch_valid/ready       descriptor handshake
//   launch_addr/data         NUM_DCRS packed DCR addresses (12b) / data (32b)
//   abort                    host abort of the current run
//   dcr_wr_valid/addr/data   DCR write port to the core
//   vx_reset                 active-high reset to the core
//   busy                     core busy indication
//   done_valid/ready         completion record handshake
//   done_status              00 ok, 10 start timeout, 11 aborted
//   done_cycles              cycles the core spent out of reset
module vortex_launch_ctrl #(
  parameter int unsigned NUM_DCRS      = 4,
  parameter int unsigned START_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     launch_valid,
  output logic                     launch_ready,
  input  logic [NUM_DCRS*12-1:0]   launch_addr,
  input  logic [NUM_DCRS*32-1:0]   launch_data,
  input  logic                     abort,
  output logic                     dcr_wr_valid,
  output logic [11:0]              dcr_wr_addr,
  output logic [31:0]              dcr_wr_data,
  output logic                     vx_reset,
  input  logic                     busy,
  output logic                     done_valid,
  input  logic                     done_ready,
  output logic [1:0]               done_status,
  output logic [31:0]              done_cycles
);

  localparam int unsigned AW    = NUM_DCRS * 12;
  localparam int unsigned DW    = NUM_DCRS * 32;
  localparam int unsigned IDX_W = (NUM_DCRS > 1) ? $clog2(NUM_DCRS) : 1;
  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic [AW-1:0]      r_addr_sh, w_addr_sh;
  logic [DW-1:0]      r_data_sh, w_data_sh;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;

  logic               r_launch_ready, w_launch_ready;
  logic               r_vx_reset, w_vx_reset;
  logic               r_dcr_valid, w_dcr_valid;
  logic [11:0]        r_dcr_addr, w_dcr_addr;
  logic [31:0]        r_dcr_data, w_dcr_data;
  logic               r_done_valid, w_done_valid;
  logic [1:0]         r_done_status, w_done_status;
  logic [CNT_W-1:0]   r_done_cycles, w_done_cycles;

  // Saturating run counter increment; the value reported includes the exit cycle.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_addr_sh      <= '0;
      r_data_sh      <= '0;
      r_cnt          <= '0;
      r_launch_ready <= 1'b1;
      r_vx_reset     <= 1'b1;
      r_dcr_valid    <= 1'b0;
      r_dcr_addr     <= '0;
      r_dcr_data     <= '0;
      r_done_valid   <= 1'b0;
      r_done_status  <= ST_OK;
      r_done_cycles  <= '0;
    end else begin
      r_state        <= w_state;
      r_idx          <= w_idx;
      r_addr_sh      <= w_addr_sh;
      r_data_sh      <= w_data_sh;
      r_cnt          <= w_cnt;
      r_launch_ready <= w_launch_ready;
      r_vx_reset     <= w_vx_reset;
      r_dcr_valid    <= w_dcr_valid;
      r_dcr_addr     <= w_dcr_addr;
      r_dcr_data     <= w_dcr_data;
      r_done_valid   <= w_done_valid;
      r_done_status  <= w_done_status;
      r_done_cycles  <= w_done_cycles;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so that registering them gives the required cycle alignment.
  always_comb begin
    w_state        = r_state;
    w_idx          = r_idx;
    w_addr_sh      = r_addr_sh;
    w_data_sh      = r_data_sh;
    w_cnt          = r_cnt;
    w_launch_ready = 1'b0;
    w_vx_reset     = 1'b1;
    w_dcr_valid    = 1'b0;
    w_dcr_addr     = '0;
    w_dcr_data     = '0;
    w_done_valid   = r_done_valid;
    w_done_status  = r_done_status;
    w_done_cycles  = r_done_cycles;

    case (r_state)
      S_IDLE: begin
        w_launch_ready = 1'b1;
        if (launch_valid && r_launch_ready) begin
          // Entry 0 goes straight out; the rest are held in shift registers.
          w_state        = S_CFG;
          w_idx          = '0;
          w_cnt          = '0;
          w_launch_ready = 1'b0;
          w_dcr_valid    = 1'b1;
          w_dcr_addr     = launch_addr[11:0];
          w_dcr_data     = launch_data[31:0];
          w_addr_sh      = launch_addr >> 12;
          w_data_sh      = launch_data >> 32;
        end
      end

      S_CFG: begin
        // r_idx is the entry currently on the DCR bus.
        if (r_idx == IDX_W'(NUM_DCRS - 1)) begin
          w_state    = S_WAIT_BUSY;
          w_vx_reset = 1'b0;
        end else begin
          w_idx       = r_idx + IDX_W'(1);
          w_dcr_valid = 1'b1;
          w_dcr_addr  = r_addr_sh[11:0];
          w_dcr_data  = r_data_sh[31:0];
          w_addr_sh   = r_addr_sh >> 12;
          w_data_sh   = r_data_sh >> 32;
        end
      end

      S_WAIT_BUSY: begin
        w_vx_reset = 1'b0;
        w_cnt      = w_cnt_inc;
        if (abort) begin
          w_state       = S_DONE;
          w_vx_reset    = 1'b1;
          w_done_valid  = 1'b1;
          w_done_status = ST_ABORT;
          w_done_cycles = w_cnt_inc;
        end else if (busy) begin
          w_state = S_RUN;
        end else if (w_cnt_inc >= CNT_W'(START_TIMEOUT)) begin
          w_state       = S_DONE;
          w_vx_reset    = 1'b1;
          w_done_valid  = 1'b1;
          w_done_status = ST_TIMEOUT;
          w_done_cycles = w_cnt_inc;
        end
      end

      S_RUN: begin
        w_vx_reset = 1'b0;
        w_cnt      = w_cnt_inc;
        if (abort || !busy) begin
          w_state       = S_DONE;
          w_vx_reset    = 1'b1;
          w_done_valid  = 1'b1;
          w_done_status = abort ? ST_ABORT : ST_OK;
          w_done_cycles = w_cnt_inc;
        end
      end

      S_DONE: begin
        if (r_done_valid && done_ready) begin
          w_state        = S_IDLE;
          w_done_valid   = 1'b0;
          w_launch_ready = 1'b1;
        end
      end

      default: begin
        w_state        = S_IDLE;
        w_launch_ready = 1'b1;
        w_done_valid   = 1'b0;
      end
    endcase
  end

  assign launch_ready = r_launch_ready;
  assign vx_reset     = r_vx_reset;
  assign dcr_wr_valid = r_dcr_valid;
  assign dcr_wr_addr  = r_dcr_addr;
  assign dcr_wr_data  = r_dcr_data;
  assign done_valid   = r_done_valid;
  assign done_status  = r_done_status;
  assign done_cycles  = r_done_cycles;

endmodule

// File: tb/tb_vortex_launch_ctrl.sv
// Self-checking bench for vortex_launch_ctrl: table of launch scenarios plus
// hand-written reset sequences.
module tb_vortex_launch_ctrl;

  localparam int unsigned NUM_DCRS      = 4;
  localparam int unsigned START_TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   launch_valid;
  logic                   launch_ready;
  logic [NUM_DCRS*12-1:0] launch_addr;
  logic [NUM_DCRS*32-1:0] launch_data;
  logic                   abort;
  logic                   dcr_wr_valid;
  logic [11:0]            dcr_wr_addr;
  logic [31:0]            dcr_wr_data;
  logic                   vx_reset;
  logic                   busy;
  logic                   done_valid;
  logic                   done_ready;
  logic [1:0]             done_status;
  logic [31:0]            done_cycles;

  vortex_launch_ctrl #(
    .NUM_DCRS      (NUM_DCRS),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .launch_valid (launch_valid),
    .launch_ready (launch_ready),
    .launch_addr  (launch_addr),
    .launch_data  (launch_data),
    .abort        (abort),
    .dcr_wr_valid (dcr_wr_valid),
    .dcr_wr_addr  (dcr_wr_addr),
    .dcr_wr_data  (dcr_wr_data),
    .vx_reset     (vx_reset),
    .busy         (busy),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_status  (done_status),
    .done_cycles  (done_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0]  addr;
    logic [127:0] data;
    int           busy_delay;  // cycles after reset release before busy rises
    int           run_len;     // cycles busy stays high (0 = never)
    int           abort_at;    // cycle (from reset release) abort is high, -1 none
    int           bp;          // cycles done_ready held low after done_valid
    bit           scramble;    // change launch inputs every CFG cycle
    logic [1:0]   exp_status;
    logic [31:0]  exp_cycles;
  } vec_t;

  vec_t vecs[8];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_launch_ready"}, 128'(launch_ready), 128'(1));
    check({tag, "_vx_reset"},     128'(vx_reset),     128'(1));
    check({tag, "_dcr_valid"},    128'(dcr_wr_valid), 128'(0));
    check({tag, "_dcr_addr"},     128'(dcr_wr_addr),  128'(0));
    check({tag, "_dcr_data"},     128'(dcr_wr_data),  128'(0));
    check({tag, "_done_valid"},   128'(done_valid),   128'(0));
    check({tag, "_done_status"},  128'(done_status),  128'(0));
    check({tag, "_done_cycles"},  128'(done_cycles),  128'(0));
  endtask

  // Runs one launch from an IDLE negedge through completion and drain.
  task automatic run_launch(input vec_t v, input int id);
    int k;
    int n_low;
    check($sformatf("v%0d_idle_ready", id), 128'(launch_ready), 128'(1));
    check($sformatf("v%0d_idle_vxrst", id), 128'(vx_reset), 128'(1));
    launch_addr  = v.addr;
    launch_data  = v.data;
    launch_valid = 1'b1;
    @(negedge clk);
    launch_valid = 1'b0;
    for (int i = 0; i < int'(NUM_DCRS); i++) begin
      check($sformatf("v%0d_cfg%0d_valid", id, i), 128'(dcr_wr_valid), 128'(1));
      check($sformatf("v%0d_cfg%0d_addr", id, i), 128'(dcr_wr_addr), 128'(v.addr[12*i +: 12]));
      check($sformatf("v%0d_cfg%0d_data", id, i), 128'(dcr_wr_data), 128'(v.data[32*i +: 32]));
      check($sformatf("v%0d_cfg%0d_vxrst", id, i), 128'(vx_reset), 128'(1));
      check($sformatf("v%0d_cfg%0d_ready", id, i), 128'(launch_ready), 128'(0));
      if (v.scramble) begin
        launch_addr = 48'({$urandom(), $urandom()});
        launch_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
    end
    check($sformatf("v%0d_wait_dcr_valid", id), 128'(dcr_wr_valid), 128'(0));
    check($sformatf("v%0d_wait_dcr_addr", id), 128'(dcr_wr_addr), 128'(0));
    check($sformatf("v%0d_wait_dcr_data", id), 128'(dcr_wr_data), 128'(0));
    check($sformatf("v%0d_wait_vxrst", id), 128'(vx_reset), 128'(0));

    n_low = 0;
    k     = 0;
    while (k < 200 && done_valid !== 1'b1) begin
      if (vx_reset === 1'b0) n_low++;
      busy  = (k >= v.busy_delay && k < v.busy_delay + v.run_len) ? 1'b1 : 1'b0;
      abort = (k == v.abort_at) ? 1'b1 : 1'b0;
      @(negedge clk);
      k++;
    end
    busy  = 1'b0;
    abort = 1'b0;
    check($sformatf("v%0d_done_seen", id), 128'(done_valid), 128'(1));
    check($sformatf("v%0d_done_vxrst", id), 128'(vx_reset), 128'(1));
    check($sformatf("v%0d_done_status", id), 128'(done_status), 128'(v.exp_status));
    check($sformatf("v%0d_done_cycles", id), 128'(done_cycles), 128'(v.exp_cycles));
    check($sformatf("v%0d_low_cycles", id), 128'(n_low), 128'(v.exp_cycles));
    check($sformatf("v%0d_done_ready_out", id), 128'(launch_ready), 128'(0));

    // Hold the record with a competing launch and an abort pulse.
    for (int j = 0; j < v.bp; j++) begin
      launch_addr  = 48'hFFF_FFF_FFF_FFF;
      launch_data  = '1;
      launch_valid = 1'b1;
      abort        = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_bp%0d_valid", id, j), 128'(done_valid), 128'(1));
      check($sformatf("v%0d_bp%0d_status", id, j), 128'(done_status), 128'(v.exp_status));
      check($sformatf("v%0d_bp%0d_cycles", id, j), 128'(done_cycles), 128'(v.exp_cycles));
      check($sformatf("v%0d_bp%0d_ready", id, j), 128'(launch_ready), 128'(0));
      check($sformatf("v%0d_bp%0d_dcr", id, j), 128'(dcr_wr_valid), 128'(0));
    end
    abort      = 1'b0;
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    check($sformatf("v%0d_drain_valid", id), 128'(done_valid), 128'(0));
    check($sformatf("v%0d_drain_ready", id), 128'(launch_ready), 128'(1));
    check($sformatf("v%0d_drain_vxrst", id), 128'(vx_reset), 128'(1));
    check($sformatf("v%0d_drain_dcr", id), 128'(dcr_wr_valid), 128'(0));
    launch_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {addr, data, busy_delay, run_len, abort_at, bp, scramble, status, cycles}
    vecs[0] = '{48'h004_003_002_001, 128'h000000A3_000000A2_000000A1_000000A0,
                3, 20, -1, 0, 1'b0, 2'b00, 32'd24};
    vecs[1] = '{48'h123_456_789_ABC, 128'h11111111_22222222_33333333_44444444,
                0, 0, -1, 0, 1'b0, 2'b10, 32'd16};
    vecs[2] = '{48'h010_020_030_040, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF,
                3, 11, 14, 0, 1'b0, 2'b11, 32'd15};
    vecs[3] = '{48'h0FF_0EE_0DD_0CC, 128'h0000000F_000000F0_00000F00_0000F000,
                0, 0, 5, 0, 1'b0, 2'b11, 32'd6};
    vecs[4] = '{48'hA00_B00_C00_D00, 128'h80000000_40000000_20000000_10000000,
                0, 0, 15, 0, 1'b0, 2'b11, 32'd16};
    vecs[5] = '{48'h111_222_333_444, 128'h55555555_66666666_77777777_88888888,
                15, 2, -1, 0, 1'b0, 2'b00, 32'd18};
    vecs[6] = '{48'h800_400_200_100, 128'h00000001_00000002_00000004_00000008,
                1, 4, -1, 5, 1'b0, 2'b00, 32'd6};
    vecs[7] = '{48'h7FF_5A5_A5A_001, 128'hFEEDFACE_0BADC0DE_13579BDF_2468ACE0,
                0, 1, -1, 0, 1'b1, 2'b00, 32'd2};

    reset_n      = 1'b0;
    launch_valid = 1'b0;
    launch_addr  = '0;
    launch_data  = '0;
    abort        = 1'b0;
    busy         = 1'b0;
    done_ready   = 1'b0;
    @(negedge clk);
    check_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_por");

    // Reset in the middle of CFG after two DCR writes.
    launch_addr  = 48'h00C_00B_00A_009;
    launch_data  = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    launch_valid = 1'b1;
    @(negedge clk);
    launch_valid = 1'b0;
    check("midrst_cfg0_addr", 128'(dcr_wr_addr), 128'(12'h009));
    @(negedge clk);
    check("midrst_cfg1_addr", 128'(dcr_wr_addr), 128'(12'h00A));
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst_async");
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("midrst_hold%0d_dcr", j), 128'(dcr_wr_valid), 128'(0));
      check($sformatf("midrst_hold%0d_vxrst", j), 128'(vx_reset), 128'(1));
    end
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst_release");
    check("midrst_done_idle", 128'(done_valid), 128'(0));

    for (int v = 0; v < 8; v++) begin
      run_launch(vecs[v], v);
    end

    repeat (3) @(negedge clk);
    check("final_idle_dcr", 128'(dcr_wr_valid), 128'(0));
    check("final_idle_ready", 128'(launch_ready), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
